// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the sequential 16-bit ripple-borrow subtractor:
// FSM state encoding, operand width, nibble count and nibble-index width.
// No ports (package).
// -----------------------------------------------------------------------------
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH   = 16;
   localparam int NIBBLES = 4;
   localparam int IDX_W   = 2;

endpackage : sub_pkg

// File: rtl/RBS4b.sv
// -----------------------------------------------------------------------------
// RBS4b
// Combinational 4-bit ripple-borrow subtractor: {bout, d} = a - b - bin,
// built from four full-subtractor bit cells chained LSB to MSB.
// Ports:
//   a    in  4  minuend nibble
//   b    in  4  subtrahend nibble
//   bin  in  1  borrow-in (active high)
//   d    out 4  difference nibble
//   bout out 1  borrow-out (active high)
// -----------------------------------------------------------------------------
module RBS4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [4:0] borrowChain;

   assign borrowChain[0] = bin;

   for (genvar i = 0; i < 4; i++) begin : gBitCell
      // Full subtractor: borrow when a < b, or when a == b and a borrow arrives.
      assign d[i]              = a[i] ^ b[i] ^ borrowChain[i];
      assign borrowChain[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrowChain[i]);
   end

   assign bout = borrowChain[4];

endmodule : RBS4b

// File: rtl/seq_sub16.sv
// -----------------------------------------------------------------------------
// seq_sub16
// Multi-cycle 16-bit subtractor: D = A - B - BIN, one nibble per clock
// through a single RBS4b slice. Operands accepted over a valid/ready
// handshake in IDLE, four BUSY cycles (nibble 0..3), result held in DONE
// until the downstream handshake.
// Optional feature: define SEQ_SUB16_OVF_EN to add the registered signed
// overflow output OVF.
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   asynchronous active-high reset
//   in_valid   in  1   operands present
//   in_ready   out 1   high only in IDLE
//   arrayA     in  16  minuend
//   arrayB     in  16  subtrahend
//   BIN        in  1   borrow-in
//   out_valid  out 1   high only in DONE
//   out_ready  in  1   downstream accepts result
//   arrayD     out 16  difference (registered)
//   BOUT       out 1   borrow-out (registered)
//   OVF        out 1   signed overflow (registered, SEQ_SUB16_OVF_EN only)
// -----------------------------------------------------------------------------
module seq_sub16
   import sub_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  arrayA,
   input  logic [WIDTH-1:0]  arrayB,
   input  logic              BIN,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  arrayD,
`ifdef SEQ_SUB16_OVF_EN
   output logic              OVF,
`endif
   output logic              BOUT
);

   state_t           state;
   state_t           stateNext;
   logic [IDX_W-1:0] idx;
   logic             borrow;
   logic [WIDTH-1:0] regA;
   logic [WIDTH-1:0] regB;
   logic             accept;
   logic             lastNibble;
   logic [3:0]       nibA;
   logic [3:0]       nibB;
   logic [3:0]       sliceD;
   logic             sliceB;

   // Handshake flags decode straight from the state register, so neither
   // ready nor valid depends combinationally on the opposite-side input.
   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign accept     = in_valid && in_ready;
   assign lastNibble = (idx == IDX_W'(NIBBLES - 1));

   // Nibble select feeding the single shared slice.
   assign nibA = regA[{idx, 2'b00} +: 4];
   assign nibB = regB[{idx, 2'b00} +: 4];

   RBS4b uSlice (
      .a    (nibA),
      .b    (nibB),
      .bin  (borrow),
      .d    (sliceD),
      .bout (sliceB)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (in_valid)   stateNext = BUSY;
         BUSY:    if (lastNibble) stateNext = DONE;
         DONE:    if (out_ready)  stateNext = IDLE;
         default:                 stateNext = IDLE;
      endcase
   end

   // Operand capture; only meaningful after an accept, so no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         regA <= arrayA;
         regB <= arrayB;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         borrow <= 1'b0;
         arrayD <= '0;
         BOUT   <= 1'b0;
`ifdef SEQ_SUB16_OVF_EN
         OVF    <= 1'b0;
`endif
      end else begin
         if (accept) begin
            idx    <= '0;
            borrow <= BIN;
         end else if (state == BUSY) begin
            arrayD[{idx, 2'b00} +: 4] <= sliceD;
            borrow <= sliceB;
            idx    <= idx + IDX_W'(1);
            if (lastNibble) begin
               BOUT <= sliceB;
`ifdef SEQ_SUB16_OVF_EN
               // Operands of opposite sign and result sign differing from A.
               OVF  <= (regA[WIDTH-1] != regB[WIDTH-1]) && (sliceD[3] != regA[WIDTH-1]);
`endif
            end
         end
      end
   end

endmodule : seq_sub16

// File: tb/tb_seq_sub16.sv
// -----------------------------------------------------------------------------
// tb_seq_sub16
// Directed self-checking bench for seq_sub16.
// -----------------------------------------------------------------------------
module tb_seq_sub16;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] arrayA;
   logic [15:0] arrayB;
   logic        BIN;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] arrayD;
   logic        BOUT;
`ifdef SEQ_SUB16_OVF_EN
   logic        OVF;
`endif

   int checks   = 0;
   int failures = 0;
   int lat;

   seq_sub16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .arrayA    (arrayA),
      .arrayB    (arrayB),
      .BIN       (BIN),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .arrayD    (arrayD),
`ifdef SEQ_SUB16_OVF_EN
      .OVF       (OVF),
`endif
      .BOUT      (BOUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands, wait for the accept edge, then count edges until
   // out_valid (bounded). Returns sampled #1 after the edge where DONE is seen.
   task automatic doOp(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       output int latency);
      arrayA   = a;
      arrayB   = b;
      BIN      = bi;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      latency  = 0;
      while (!out_valid && latency < 20) begin
         @(posedge clk);
         #1;
         latency++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      arrayA    = '0;
      arrayB    = '0;
      BIN       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_arrayD",    arrayD,    0);
      chk("rst_BOUT",      BOUT,      0);
`ifdef SEQ_SUB16_OVF_EN
      chk("rst_OVF",       OVF,       0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 0x1234 - 0x0234
      doOp(16'h1234, 16'h0234, 1'b0, lat);
      chk("t1_latency",   lat,       4);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_in_ready",  in_ready,  0);
      chk("t1_arrayD",    arrayD,    16'h1000);
      chk("t1_BOUT",      BOUT,      0);
`ifdef SEQ_SUB16_OVF_EN
      chk("t1_OVF",       OVF,       0);
`endif
      @(posedge clk);
      #1;
      chk("t1_idle_in_ready",  in_ready,  1);
      chk("t1_idle_out_valid", out_valid, 0);

      // Wrap-around: 0x0000 - 0x0001
      doOp(16'h0000, 16'h0001, 1'b0, lat);
      chk("t2_latency", lat,    4);
      chk("t2_arrayD",  arrayD, 16'hFFFF);
      chk("t2_BOUT",    BOUT,   1);
      @(posedge clk);
      #1;

      // Borrow across a nibble boundary: 0x00F0 - 0x000F - 1
      doOp(16'h00F0, 16'h000F, 1'b1, lat);
      chk("t3_latency", lat,    4);
      chk("t3_arrayD",  arrayD, 16'h00E0);
      chk("t3_BOUT",    BOUT,   0);
      @(posedge clk);
      #1;

      // Signed overflow: 0x8000 - 0x0001
      doOp(16'h8000, 16'h0001, 1'b0, lat);
      chk("t4_latency", lat,    4);
      chk("t4_arrayD",  arrayD, 16'h7FFF);
      chk("t4_BOUT",    BOUT,   0);
`ifdef SEQ_SUB16_OVF_EN
      chk("t4_OVF",     OVF,    1);
`endif
      @(posedge clk);
      #1;

      // Backpressure: 0x5678 - 0x1234 held in DONE while new operands wait
      out_ready = 1'b0;
      doOp(16'h5678, 16'h1234, 1'b0, lat);
      chk("t5_latency", lat,    4);
      arrayA   = 16'hAAAA;
      arrayB   = 16'h1111;
      BIN      = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("t5_hold_out_valid", out_valid, 1);
         chk("t5_hold_in_ready",  in_ready,  0);
         chk("t5_hold_arrayD",    arrayD,    16'h4444);
         chk("t5_hold_BOUT",      BOUT,      0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_release_out_valid", out_valid, 0);
      chk("t5_release_in_ready",  in_ready,  1);
      @(posedge clk);
      #1;
      chk("t5_not_taken_in_ready", in_ready, 1);
      chk("t5_not_taken_arrayD",   arrayD,   16'h4444);

      // Reset during the second BUSY cycle: 0x1111 - 0x0001
      arrayA   = 16'h1111;
      arrayB   = 16'h0001;
      BIN      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_partial_arrayD", arrayD, 16'h4440);
      rst = 1'b1;
      #1;
      chk("t6_rst_arrayD",    arrayD,    0);
      chk("t6_rst_BOUT",      BOUT,      0);
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_in_ready",  in_ready,  1);
`ifdef SEQ_SUB16_OVF_EN
      chk("t6_rst_OVF",       OVF,       0);
`endif
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("t6_no_partial_out_valid", out_valid, 0);
      end
      arrayA = 16'hFFFF;
      BOUT_dummy_guard();
      doOp(16'hFFFF, 16'hFFFF, 1'b0, lat);
      chk("t6_fresh_latency", lat,    4);
      chk("t6_fresh_arrayD",  arrayD, 16'h0000);
      chk("t6_fresh_BOUT",    BOUT,   0);
      @(posedge clk);
      #1;
      chk("t6_fresh_idle", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Simulation time bound in case the sequence above stalls.
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1, "timeout");
   end

   task automatic BOUT_dummy_guard();
      // Nothing to prepare; kept as an explicit step marker before the fresh op.
   endtask

endmodule : tb_seq_sub16
